// File: rtl/memory_bus_arbiter_pkg.sv
// Shared bus types for the DRAM request arbiter: packet type/payload/address
// and the arbiter FSM state encoding.
package memory_bus_arbiter_pkg;

    localparam int PHYS_ADDR_W = 32;

    typedef enum logic [1:0] {
        bus_read_data  = 2'd0,
        bus_write_data = 2'd1,
        bus_read_resp  = 2'd2,
        bus_reserved   = 2'd3
    } bus_packet_type_t;

    typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;
    typedef logic [63:0]            bus_packet_payload_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    // Only plain reads and writes may be sent to DRAM.
    function automatic logic is_known_type(input logic [1:0] t);
        return (t == bus_read_data) || (t == bus_write_data);
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_priority_pick.sv
// Round-robin pick: first requester at or after ptr wins, wrapping to the
// lowest index when nothing at or above ptr is requesting.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    logic [N-1:0] masked;
    logic [N-1:0] cand;
    logic         found;

    always_comb begin
        masked = '0;
        for (int j = 0; j < N; j++) begin
            masked[j] = req[j] && (PTR_W'(j) >= ptr);
        end
        cand  = (|masked) ? masked : req;
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (cand[j] && !found) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single DRAM request channel with at
// most one transaction outstanding; read data is routed back to the grantee.
//
// state    | meaning
// IDLE     | no transaction; grant the next round-robin requester
// ISSUE    | latched packet offered to DRAM until accepted (or dropped if illegal)
// WAIT_RSP | read accepted, waiting for DRAM response tagged with our source
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = PHYS_ADDR_W,
    parameter int SRC_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*2-1:0]      req_type,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*64-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [63:0]               rsp_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [1:0]                mem_req_type,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [63:0]               mem_req_data,
    output logic [SRC_W-1:0]          mem_req_source,
    input  logic                      mem_rsp_valid,
    input  logic [63:0]               mem_rsp_data,
    input  logic [SRC_W-1:0]          mem_rsp_source,
    output logic                      err_unknown_type
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0]  pick_grant;
    logic                pick_valid;

    logic [PTR_W-1:0]    gidx;
    logic [1:0]          sel_type;
    logic [ADDR_W-1:0]   sel_addr;
    bus_packet_payload_t sel_data;

    logic [1:0]          lat_type;
    logic [ADDR_W-1:0]   lat_addr;
    bus_packet_payload_t lat_data;
    logic [SRC_W-1:0]    lat_src;
    logic [NUM_REQ-1:0]  lat_grant;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    bus_packet_payload_t rsp_data_q;
    logic                err_q;

    logic                grant_take;
    logic                set_err;
    logic                rsp_fire;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        gidx     = '0;
        sel_type = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                gidx     = PTR_W'(i);
                sel_type = req_type[2*i +: 2];
                sel_addr = req_addr[ADDR_W*i +: ADDR_W];
                sel_data = req_wdata[64*i +: 64];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = '0;
        mem_req_valid = 1'b0;
        grant_take    = 1'b0;
        set_err       = 1'b0;
        rsp_fire      = 1'b0;
        case (state_q)
            IDLE: begin
                // the grant is combinational, so hold it off while reset is low
                if (pick_valid && reset_n) begin
                    req_ready  = pick_grant;
                    grant_take = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (!is_known_type(lat_type)) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        state_d = (lat_type == bus_read_data) ? WAIT_RSP : IDLE;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid && (mem_rsp_source == lat_src)) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            lat_type    <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_src     <= '0;
            lat_grant   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (grant_take) begin
                lat_type  <= sel_type;
                lat_addr  <= sel_addr;
                lat_data  <= sel_data;
                lat_src   <= SRC_W'(gidx);
                lat_grant <= pick_grant;
                rr_ptr    <= (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + PTR_W'(1);
            end
            if (set_err) err_q <= 1'b1;
            rsp_valid_q <= rsp_fire ? lat_grant : '0;
            if (rsp_fire) rsp_data_q <= mem_rsp_data;
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign mem_req_type     = lat_type;
    assign mem_req_addr     = lat_addr;
    assign mem_req_data     = lat_data;
    assign mem_req_source   = lat_src;
    assign err_unknown_type = err_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: directed stimulus pushes expected
// grants, DRAM packets and read responses; a negedge monitor pops and compares.
module tb_memory_bus_arbiter;
    import memory_bus_arbiter_pkg::*;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [7:0]   req_type;
    logic [127:0] req_addr;
    logic [255:0] req_wdata;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [1:0]   mem_req_type;
    logic [31:0]  mem_req_addr;
    logic [63:0]  mem_req_data;
    logic [2:0]   mem_req_source;
    logic         mem_rsp_valid;
    logic [63:0]  mem_rsp_data;
    logic [2:0]   mem_rsp_source;
    logic         err_unknown_type;

    memory_bus_arbiter #(.NUM_REQ(4), .ADDR_W(32), .SRC_W(3)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_type         (req_type),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_type     (mem_req_type),
        .mem_req_addr     (mem_req_addr),
        .mem_req_data     (mem_req_data),
        .mem_req_source   (mem_req_source),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .mem_rsp_source   (mem_rsp_source),
        .err_unknown_type (err_unknown_type)
    );

    typedef struct {
        logic [1:0]  t;
        logic [31:0] a;
        logic [63:0] d;
        logic [2:0]  s;
        bit          chk_d;
    } mem_exp_t;

    typedef struct {
        int          port;
        logic [63:0] d;
    } rsp_exp_t;

    int       gq[$];
    mem_exp_t mq[$];
    rsp_exp_t rq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int rsp_cnt  = 0;
    int rsp_base;

    int       mon_gp;
    mem_exp_t mon_me;
    rsp_exp_t mon_re;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [1:0] t, input logic [31:0] a,
                            input logic [63:0] d);
        req_type[2*p +: 2]   = t;
        req_addr[32*p +: 32] = a;
        req_wdata[64*p +: 64] = d;
    endtask

    task automatic push_mem(input logic [1:0] t, input logic [31:0] a, input logic [63:0] d,
                            input logic [2:0] s, input bit chk_d);
        mem_exp_t e;
        e.t = t; e.a = a; e.d = d; e.s = s; e.chk_d = chk_d;
        mq.push_back(e);
    endtask

    task automatic push_rsp(input int p, input logic [63:0] d);
        rsp_exp_t e;
        e.port = p; e.d = d;
        rq.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (req_ready != 4'b0) begin
                if (gq.size() == 0) chk("grant_unexpected", 64'(req_ready), 64'd0);
                else begin
                    mon_gp = gq.pop_front();
                    chk("grant", 64'(req_ready), 64'd1 << mon_gp);
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mq.size() == 0) chk("mem_unexpected", 64'(mem_req_valid), 64'd0);
                else begin
                    mon_me = mq.pop_front();
                    chk("mem_type", 64'(mem_req_type), 64'(mon_me.t));
                    chk("mem_addr", 64'(mem_req_addr), 64'(mon_me.a));
                    chk("mem_source", 64'(mem_req_source), 64'(mon_me.s));
                    if (mon_me.chk_d) chk("mem_data", mem_req_data, mon_me.d);
                end
            end
            if (rsp_valid != 4'b0) begin
                rsp_cnt++;
                if (rq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                else begin
                    mon_re = rq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'd1 << mon_re.port);
                    chk("rsp_data", rsp_data, mon_re.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b1;
        req_valid      = '0;
        req_type       = '0;
        req_addr       = '0;
        req_wdata      = '0;
        mem_req_ready  = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        mem_rsp_source = '0;
        #2 reset_n = 1'b0;
        step(2);

        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_err", 64'(err_unknown_type), 64'd0);
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(IDLE));
        chk("rst_mem_addr", 64'(mem_req_addr), 64'd0);
        reset_n = 1'b1;

        // single read on port 2, DRAM answers 5 cycles after acceptance
        rsp_base = rsp_cnt;
        set_port(2, bus_read_data, 32'h40, 64'd0);
        gq.push_back(2);
        push_mem(bus_read_data, 32'h40, 64'd0, 3'd2, 1'b0);
        req_valid = 4'b0100;
        step(1);
        req_valid = 4'b0000;
        step(5);
        mem_rsp_valid  = 1'b1;
        mem_rsp_source = 3'd2;
        mem_rsp_data   = 64'h1122334455667788;
        push_rsp(2, 64'h1122334455667788);
        step(1);
        mem_rsp_valid = 1'b0;
        step(2);
        chk("read_rsp_once", 64'(rsp_cnt - rsp_base), 64'd1);

        // all four ports writing continuously from reset
        do_reset();
        for (int p = 0; p < 4; p++)
            set_port(p, bus_write_data, 32'h1000 + 32'(p) * 32'h10, 64'hD0D0_0000_0000_0000 | 64'(p));
        for (int k = 0; k < 5; k++) begin
            gq.push_back(k % 4);
            push_mem(bus_write_data, 32'h1000 + 32'(k % 4) * 32'h10,
                     64'hD0D0_0000_0000_0000 | 64'(k % 4), 3'(k % 4), 1'b1);
        end
        req_valid = 4'b1111;
        step(10);
        req_valid = 4'b0000;
        step(1);
        chk("rr_ptr_after_wrap", 64'(dut.rr_ptr), 64'd1);

        // DRAM stalls for 10 cycles while the write is offered
        mem_req_ready = 1'b0;
        set_port(1, bus_write_data, 32'h100, 64'hCAFEF00DDEADBEEF);
        gq.push_back(1);
        req_valid = 4'b0010;
        step(1);
        req_valid = 4'b0000;
        set_port(1, bus_read_data, 32'hFFFF, 64'h0);
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_type", 64'(mem_req_type), 64'(bus_write_data));
            chk("stall_addr", 64'(mem_req_addr), 64'h100);
            chk("stall_data", mem_req_data, 64'hCAFEF00DDEADBEEF);
            chk("stall_source", 64'(mem_req_source), 64'd1);
            step(1);
        end
        push_mem(bus_write_data, 32'h100, 64'hCAFEF00DDEADBEEF, 3'd1, 1'b1);
        mem_req_ready = 1'b1;
        step(2);

        // response tagged for another source is ignored
        set_port(3, bus_read_data, 32'h300, 64'd0);
        gq.push_back(3);
        push_mem(bus_read_data, 32'h300, 64'd0, 3'd3, 1'b0);
        req_valid = 4'b1000;
        step(1);
        req_valid = 4'b0000;
        step(1);
        mem_rsp_valid  = 1'b1;
        mem_rsp_source = 3'd1;
        mem_rsp_data   = 64'hBAD0BAD0BAD0BAD0;
        for (int c = 0; c < 2; c++) begin
            step(1);
            chk("mismatch_state", 64'(dut.state_q), 64'(WAIT_RSP));
            chk("mismatch_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        mem_rsp_source = 3'd3;
        mem_rsp_data   = 64'h0123456789ABCDEF;
        push_rsp(3, 64'h0123456789ABCDEF);
        step(1);
        mem_rsp_valid = 1'b0;
        step(2);

        // illegal type on port 0 is dropped and flagged
        set_port(0, 2'd3, 32'h500, 64'h5555);
        gq.push_back(0);
        req_valid = 4'b0001;
        step(1);
        req_valid = 4'b0000;
        chk("illegal_no_mem_valid", 64'(mem_req_valid), 64'd0);
        step(1);
        chk("illegal_err", 64'(err_unknown_type), 64'd1);
        chk("illegal_state_idle", 64'(dut.state_q), 64'(IDLE));
        set_port(2, bus_write_data, 32'h600, 64'h6666);
        gq.push_back(2);
        push_mem(bus_write_data, 32'h600, 64'h6666, 3'd2, 1'b1);
        req_valid = 4'b0100;
        step(1);
        req_valid = 4'b0000;
        step(2);
        chk("err_sticky", 64'(err_unknown_type), 64'd1);

        // reset asserted while waiting on a read
        set_port(1, bus_read_data, 32'h700, 64'd0);
        gq.push_back(1);
        push_mem(bus_read_data, 32'h700, 64'd0, 3'd1, 1'b0);
        req_valid = 4'b0010;
        step(1);
        req_valid = 4'b0000;
        step(1);
        chk("pre_reset_state", 64'(dut.state_q), 64'(WAIT_RSP));
        set_port(0, bus_write_data, 32'h800, 64'h8888);
        set_port(1, bus_write_data, 32'h900, 64'h9999);
        req_valid = 4'b0011;
        reset_n   = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("mid_rst_err", 64'(err_unknown_type), 64'd0);
        chk("mid_rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        chk("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
        gq.push_back(0);
        push_mem(bus_write_data, 32'h800, 64'h8888, 3'd0, 1'b1);
        #1;
        reset_n        = 1'b1;
        mem_rsp_valid  = 1'b1;
        mem_rsp_source = 3'd1;
        mem_rsp_data   = 64'hDEADDEADDEADDEAD;
        step(1);
        req_valid = 4'b0000;
        step(1);
        mem_rsp_valid = 1'b0;
        step(2);

        for (int c = 0; c < 20; c++) begin
            if (gq.size() == 0 && mq.size() == 0 && rq.size() == 0) break;
            step(1);
        end
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("mem_queue_empty", 64'(mq.size()), 64'd0);
        chk("rsp_queue_empty", 64'(rq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk is the only clock; reset_n is asynchronous, active-low.
REQ-002 SHALL take parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-003 SHALL take parameter ADDR_W, default 32, physical address width.
REQ-004 SHALL take parameter SRC_W, default 3, source-ID width; NUM_REQ <= 2**SRC_W.
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port reset_n  in  1  async active-low reset.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester request present.
REQ-008 SHALL have port req_type  in  NUM_REQ*2  per-requester bus_packet_type_t.
REQ-009 SHALL have port req_addr  in  NUM_REQ*ADDR_W  per-requester byte address.
REQ-010 SHALL have port req_wdata  in  NUM_REQ*64  per-requester write payload.
REQ-011 SHALL have port req_ready  out  NUM_REQ  one-hot request accept.
REQ-012 SHALL have port rsp_valid  out  NUM_REQ  one-hot read-response strobe.
REQ-013 SHALL have port rsp_data  out  64  read payload, shared by all requesters.
REQ-014 SHALL have port mem_req_valid  out  1  packet offered to DRAM.
REQ-015 SHALL have port mem_req_ready  in  1  DRAM accepts packet.
REQ-016 SHALL have port mem_req_type, mem_req_addr, mem_req_data, mem_req_source  out  2/ADDR_W/64/SRC_W  packet fields.
REQ-017 SHALL have port mem_rsp_valid, mem_rsp_data, mem_rsp_source  in  1/64/SRC_W  DRAM read response.
REQ-018 SHALL have port err_unknown_type  out  1  sticky illegal-type flag.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE and WAIT_RSP, with at most one DRAM transaction outstanding.
REQ-020 In IDLE with any req_valid set, SHALL grant round-robin, starting search at rr_ptr, pulse req_ready[g] for one cycle, latch the packet, and go to ISSUE.
REQ-021 After any grant g, SHALL set rr_ptr to (g+1) mod NUM_REQ; rr_ptr wraps from NUM_REQ-1 to 0.
REQ-022 In ISSUE, SHALL hold mem_req_valid=1 with stable fields until mem_req_ready=1; mem_req_source = g.
REQ-023 For a write handshake, SHALL return to IDLE on the next cycle; writes produce no rsp_valid.
REQ-024 For a read handshake, SHALL go to WAIT_RSP.
REQ-025 In WAIT_RSP with mem_rsp_valid=1 and mem_rsp_source==g, SHALL register and drive rsp_valid[g]=1 and rsp_data=mem_rsp_data one cycle later, then return to IDLE.
REQ-026 SHALL ignore mem_rsp_valid outside WAIT_RSP and with a mismatched source.
REQ-027 When the latched type is neither bus_read_data nor bus_write_data, SHALL set err_unknown_type, drop the packet without issue, and return to IDLE.
REQ-028 For a request arriving in the same cycle a response completes, SHALL not grant it until the cycle after return to IDLE.
REQ-029 SHALL give minimum latency grant->mem_req_valid of 1 cycle; a single read from IDLE to rsp_valid is 3 cycles plus DRAM latency.
REQ-030 SHALL ignore the bits of an unrequested port's req_* and never grant such a port.

Reset
REQ-031 SHALL act on reset_n low asynchronously: state=IDLE, rr_ptr=0, err_unknown_type=0, all req_ready/rsp_valid/mem_req_valid=0, latched fields=0.
REQ-032 On reset mid-transaction, SHALL abandon the transaction; a late DRAM response is ignored per REQ-026.

Structure
REQ-033 SHALL take bus_packet_type_t, bus_packet_payload_t (64-bit) and phys_memory_address_t from the shared bus package; the arbiter state enum belongs there too.
REQ-034 SHALL place the grant logic in one combinational sub-module rr_priority_pick (request vector, rr_ptr -> one-hot grant, valid).

Verification
REQ-035 The bench SHALL check: single read, port 2, addr 0x40, DRAM rsp data 0x1122334455667788 after 5 cycles -> rsp_valid[2]=1 once, rsp_data=0x1122334455667788, no other rsp_valid.
REQ-036 The bench SHALL check: all 4 ports request writes continuously from reset -> grant order 0,1,2,3,0; mem_req_source matches each.
REQ-037 The bench SHALL check: mem_req_ready held low 10 cycles in ISSUE -> mem_req_valid and fields stable all 10 cycles.
REQ-038 The bench SHALL check: response with mem_rsp_source=1 while waiting on source 3 -> ignored, FSM stays WAIT_RSP.
REQ-039 The bench SHALL check: req_type=3 on port 0 -> err_unknown_type=1, no mem_req_valid, next request served normally.
REQ-040 The bench SHALL check: reset_n pulsed low in WAIT_RSP -> all outputs 0 immediately, rr_ptr=0, next grant goes to port 0.
